// File: rtl/cart_detect_if.sv
// ----------------------------------------------------------------------------
// cart_detect_if
//   ROM download stream from the HPS loader (hps_io ioctl_* signals).
//   master : the loader, which drives the stream
//   slave  : a snooper such as cart_detect
//   Signals:
//     ioctl_download  download in progress
//     ioctl_wr        byte strobe, one cycle per byte
//     ioctl_addr      byte address within the file (17 bits)
//     ioctl_dout      byte data
// ----------------------------------------------------------------------------
interface cart_detect_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/cart_detect.sv
// ----------------------------------------------------------------------------
// cart_detect
//   Snoops the ROM download stream and classifies the cartridge bank-switch
//   scheme and SuperChip use from file size, byte signatures and a blank
//   leading RAM image. The extension-derived scheme wins whenever it is set.
//
//   Ports:
//     clk       system clock (clk_sys)
//     reset_n   asynchronous active-low reset
//     ioctl     download stream (cart_detect_if.slave)
//     ext_bs    scheme code from the filename extension, 0 = none
//     ext_sc    extension ends in "S"
//     sc_mode   0 auto, 1 force off, 2/3 force on
//     force_bs  resolved scheme code
//     sc        SuperChip enable
//     rom_size  byte count of the last download (saturates at 0x1FFFF)
//     done      one-cycle pulse when the outputs update
//
//   Build option: define CART_DETECT_SC_EN to build the blank-image check
//   that lets auto mode enable SuperChip on its own.
// ----------------------------------------------------------------------------
module cart_detect #(
    parameter int SC_SPAN  = 128,
    parameter int E3F_HITS = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    cart_detect_if.slave  ioctl,
    input  logic [3:0]    ext_bs,
    input  logic          ext_sc,
    input  logic [1:0]    sc_mode,
    output logic [3:0]    force_bs,
    output logic          sc,
    output logic [16:0]   rom_size,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, RESOLVE, DONE} state_t;

    state_t      state;
    logic        dl_q, dl_q2;
    logic        rise, fall;
    logic [16:0] byte_cnt;
    logic [16:0] prev_addr;
    logic [7:0]  w0, w1;
    logic [1:0]  win_len;
    logic [1:0]  hit_3f, hit_e0, hit_e7, hit_ua, hit_fe;
    logic        blank_hit;

    // Edges are taken from two registered copies so each edge acts one cycle
    // after the level is first sampled.
    assign rise = dl_q & ~dl_q2;
    assign fall = ~dl_q & dl_q2;

    // Signature matching on {W1, W0, new byte}; a non-contiguous address
    // invalidates the window for this write.
    logic [1:0] eff_len;
    logic       low_addr;
    logic       m_3f, m_e0, m_e7, m_ua, m_fe;
    logic       ok_3f;
    logic [3:0] det;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        eff_len  = (ioctl.ioctl_addr == prev_addr + 17'd1) ? win_len : 2'd0;
        low_addr = ~ioctl.ioctl_addr[16];
        m_3f = (eff_len >= 2'd1) && (w0 == 8'h85) && (ioctl.ioctl_dout == 8'h3F);
        m_e0 = (eff_len == 2'd2) && (w1 inside {8'h8D, 8'hAD, 8'h2C})
            && (w0 inside {[8'hE0:8'hE7]}) && (ioctl.ioctl_dout inside {8'h1F, 8'h5F, 8'hFF});
        m_e7 = (eff_len == 2'd2) && (w1 inside {8'h8D, 8'hAD})
            && (w0 inside {8'hE5, 8'hE6}) && (ioctl.ioctl_dout inside {8'h1F, 8'hFF});
        m_ua = (eff_len == 2'd2) && (w1 inside {8'h8D, 8'hAD})
            && (w0 == 8'h40) && (ioctl.ioctl_dout == 8'h02);
        m_fe = (eff_len == 2'd2) && (w1 == 8'h20) && (w0 == 8'h00) && (ioctl.ioctl_dout == 8'hD0);
    end

    // Size-driven classification, first matching rule wins.
    always_comb begin
        ok_3f = {30'd0, hit_3f} >= 32'(E3F_HITS);
        det   = 4'd0;
        if (byte_cnt == 17'd10240 || byte_cnt == 17'd10495)
            det = 4'd7;
        else if (byte_cnt <= 17'd4096)
            det = 4'd0;
        else if (byte_cnt == 17'd8192)
            det = (hit_e0 != 2'd0) ? 4'd4 : ok_3f ? 4'd5 : (hit_ua != 2'd0) ? 4'd11
                : (hit_fe != 2'd0) ? 4'd3 : 4'd1;
        else if (byte_cnt == 17'd12288)
            det = 4'd8;
        else if (byte_cnt == 17'd16384)
            det = (hit_e7 != 2'd0) ? 4'd12 : ok_3f ? 4'd5 : 4'd2;
        else if (byte_cnt == 17'd32768)
            det = ok_3f ? 4'd5 : 4'd6;
        else if (byte_cnt == 17'h10000)
            det = ok_3f ? 4'd5 : 4'd13;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dl_q      <= 1'b0;
            dl_q2     <= 1'b0;
            byte_cnt  <= '0;
            prev_addr <= '0;
            w0        <= '0;
            w1        <= '0;
            win_len   <= '0;
            hit_3f    <= '0;
            hit_e0    <= '0;
            hit_e7    <= '0;
            hit_ua    <= '0;
            hit_fe    <= '0;
            force_bs  <= '0;
            sc        <= 1'b0;
            rom_size  <= '0;
            done      <= 1'b0;
        end else begin
            dl_q  <= ioctl.ioctl_download;
            dl_q2 <= dl_q;
            done  <= 1'b0;

            // Commit even if a new download starts in the same cycle, so
            // back-to-back loads with one idle cycle still report.
            if (state == RESOLVE) begin
                force_bs <= (ext_bs != 4'd0) ? ext_bs : det;
                sc       <= (sc_mode == 2'd1) ? 1'b0 : sc_mode[1] ? 1'b1 : (ext_sc | blank_hit);
                rom_size <= byte_cnt;
                done     <= 1'b1;
            end

            if (rise) begin
                state    <= LOAD;
                byte_cnt <= '0;
                win_len  <= '0;
                hit_3f   <= '0;
                hit_e0   <= '0;
                hit_e7   <= '0;
                hit_ua   <= '0;
                hit_fe   <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LOAD: begin
                        if (ioctl.ioctl_wr) begin
                            if (byte_cnt != 17'h1FFFF) byte_cnt <= byte_cnt + 17'd1;
                            prev_addr <= ioctl.ioctl_addr;
                            w1        <= w0;
                            w0        <= ioctl.ioctl_dout;
                            win_len   <= (eff_len == 2'd2) ? 2'd2 : eff_len + 2'd1;
                            if (low_addr) begin
                                if (m_3f && hit_3f != 2'd3) hit_3f <= hit_3f + 2'd1;
                                if (m_e0 && hit_e0 != 2'd3) hit_e0 <= hit_e0 + 2'd1;
                                if (m_e7 && hit_e7 != 2'd3) hit_e7 <= hit_e7 + 2'd1;
                                if (m_ua && hit_ua != 2'd3) hit_ua <= hit_ua + 2'd1;
                                if (m_fe && hit_fe != 2'd3) hit_fe <= hit_fe + 2'd1;
                            end
                        end
                        if (fall) state <= RESOLVE;
                    end
                    RESOLVE: state <= DONE;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CART_DETECT_SC_EN
    // Blank SuperChip RAM image: bytes 1..SC_SPAN-1 all equal byte 0.
    logic       blank;
    logic [7:0] byte0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank <= 1'b0;
            byte0 <= '0;
        end else if (rise) begin
            blank <= 1'b1;
            byte0 <= '0;
        end else if (state == LOAD && ioctl.ioctl_wr) begin
            if (ioctl.ioctl_addr == 17'd0)
                byte0 <= ioctl.ioctl_dout;
            else if (32'(ioctl.ioctl_addr) < 32'(SC_SPAN) && ioctl.ioctl_dout != byte0)
                blank <= 1'b0;
        end
    end

    assign blank_hit = blank & (byte_cnt >= 17'd8192);
`else
    assign blank_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cart_detect.sv
// ----------------------------------------------------------------------------
// tb_cart_detect
//   Streams directed and randomized ROM images into cart_detect and compares
//   force_bs, sc, rom_size and the done pulse against a reference model that
//   scans the written byte list directly.
// ----------------------------------------------------------------------------
module tb_cart_detect;

    localparam int SC_SPAN  = 128;
    localparam int E3F_HITS = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  ext_bs;
    logic        ext_sc;
    logic [1:0]  sc_mode;
    logic [3:0]  force_bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        done;

    always #5 clk = ~clk;

    cart_detect_if bus ();

    cart_detect #(.SC_SPAN(SC_SPAN), .E3F_HITS(E3F_HITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ioctl    (bus),
        .ext_bs   (ext_bs),
        .ext_sc   (ext_sc),
        .sc_mode  (sc_mode),
        .force_bs (force_bs),
        .sc       (sc),
        .rom_size (rom_size),
        .done     (done)
    );

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  prev_bs;
    logic        prev_sc;
    logic [16:0] prev_size;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Image builders: contiguous addresses, constant fill or low filler bytes
    // (0x00..0x1F) that can never start any signature.
    function automatic void build(input int n, input int fill);
        wr_t w;
        q.delete();
        for (int i = 0; i < n; i++) begin
            w.addr = 17'(i);
            w.data = (fill < 0) ? 8'($urandom_range(0, 31)) : 8'(fill);
            q.push_back(w);
        end
    endfunction

    function automatic void poke(input int idx, input logic [7:0] d);
        q[idx].data = d;
    endfunction

    function automatic void gap_from(input int idx);
        for (int i = idx; i < q.size(); i++) q[i].addr = q[i].addr + 17'd1;
    endfunction

    // Reference model: walks the write list, looking back at the previous one
    // or two writes only when their addresses run consecutively.
    function automatic void model(output logic [3:0] e_bs, output logic e_sc,
                                  output logic [16:0] e_size);
        int         n3f, ne0, ne7, nua, nfe, s, det;
        bit         blank, c1, c2;
        logic [7:0] b0, x, y, z;
        n3f = 0; ne0 = 0; ne7 = 0; nua = 0; nfe = 0;
        blank = 1'b1; b0 = 8'h00;
        for (int i = 0; i < q.size(); i++) begin
            z = q[i].data; x = 8'h00; y = 8'h00; c1 = 1'b0; c2 = 1'b0;
            if (i >= 1) c1 = (q[i].addr == q[i-1].addr + 17'd1);
            if (i >= 2) c2 = c1 && (q[i-1].addr == q[i-2].addr + 17'd1);
            if (c1) y = q[i-1].data;
            if (c2) x = q[i-2].data;
            if (int'(q[i].addr) < 'h10000) begin
                if (c1 && y == 8'h85 && z == 8'h3F) n3f++;
                if (c2 && (x inside {8'h8D, 8'hAD, 8'h2C}) && (y inside {[8'hE0:8'hE7]})
                    && (z inside {8'h1F, 8'h5F, 8'hFF})) ne0++;
                if (c2 && (x inside {8'h8D, 8'hAD}) && (y inside {8'hE5, 8'hE6})
                    && (z inside {8'h1F, 8'hFF})) ne7++;
                if (c2 && (x inside {8'h8D, 8'hAD}) && y == 8'h40 && z == 8'h02) nua++;
                if (c2 && x == 8'h20 && y == 8'h00 && z == 8'hD0) nfe++;
            end
            if (q[i].addr == 17'd0) b0 = z;
            else if (int'(q[i].addr) < SC_SPAN && z != b0) blank = 1'b0;
        end
        s = (q.size() > 'h1FFFF) ? 'h1FFFF : q.size();
        if (s == 10240 || s == 10495)  det = 7;
        else if (s <= 4096)            det = 0;
        else if (s == 8192)            det = (ne0 > 0) ? 4 : (n3f >= E3F_HITS) ? 5 : (nua > 0) ? 11 : (nfe > 0) ? 3 : 1;
        else if (s == 12288)           det = 8;
        else if (s == 16384)           det = (ne7 > 0) ? 12 : (n3f >= E3F_HITS) ? 5 : 2;
        else if (s == 32768)           det = (n3f >= E3F_HITS) ? 5 : 6;
        else if (s == 65536)           det = (n3f >= E3F_HITS) ? 5 : 13;
        else                           det = 0;
        e_bs   = (ext_bs != 4'd0) ? ext_bs : 4'(det);
        e_size = 17'(s);
`ifdef CART_DETECT_SC_EN
        if (sc_mode == 2'd1)      e_sc = 1'b0;
        else if (sc_mode >= 2'd2) e_sc = 1'b1;
        else                      e_sc = ext_sc | (blank && s >= 8192);
`else
        if (sc_mode == 2'd1)      e_sc = 1'b0;
        else if (sc_mode >= 2'd2) e_sc = 1'b1;
        else                      e_sc = ext_sc;
`endif
    endfunction

    // Streams q one byte per cycle; the last byte goes out together with the
    // falling edge of ioctl_download. Called and returns at a negedge.
    task automatic play(input bit chained);
        if (!chained) begin
            bus.ioctl_download = 1'b1;
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < q.size(); i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = q[i].addr;
            bus.ioctl_dout = q[i].data;
            if (i == q.size() - 1) bus.ioctl_download = 1'b0;
            @(negedge clk);
        end
        bus.ioctl_wr = 1'b0;
    endtask

    // Starts just after the edge that sampled ioctl_download low (edge N).
    task automatic finish_load(input string name, input bit chain_next);
        logic [3:0]  e_bs;
        logic        e_sc;
        logic [16:0] e_size;
        model(e_bs, e_sc, e_size);
        if (chain_next) bus.ioctl_download = 1'b1;
        check($sformatf("%s.done_n0", name), done, 1'b0);
        check($sformatf("%s.hold_bs", name), force_bs, prev_bs);
        check($sformatf("%s.hold_size", name), rom_size, prev_size);
        @(negedge clk);
        check($sformatf("%s.done_n1", name), done, 1'b0);
        check($sformatf("%s.hold_sc", name), sc, prev_sc);
        @(negedge clk);
        check($sformatf("%s.done_n2", name), done, 1'b1);
        check($sformatf("%s.force_bs", name), force_bs, e_bs);
        check($sformatf("%s.sc", name), sc, e_sc);
        check($sformatf("%s.rom_size", name), rom_size, e_size);
        @(negedge clk);
        check($sformatf("%s.done_n3", name), done, 1'b0);
        check($sformatf("%s.keep_bs", name), force_bs, e_bs);
        prev_bs = e_bs; prev_sc = e_sc; prev_size = e_size;
    endtask

    task automatic set_mode(input logic [3:0] b, input logic s, input logic [1:0] m);
        ext_bs = b; ext_sc = s; sc_mode = m;
    endtask

    initial begin
        logic       seen_done;
        bit         chain;
        logic [7:0] sig [5][3];
        sig[0] = '{8'h8D, 8'hE3, 8'h1F};
        sig[1] = '{8'h85, 8'h3F, 8'h00};
        sig[2] = '{8'h8D, 8'h40, 8'h02};
        sig[3] = '{8'h20, 8'h00, 8'hD0};
        sig[4] = '{8'hAD, 8'hE6, 8'hFF};

        reset_n = 1'b0;
        bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        set_mode(4'd0, 1'b0, 2'd0);
        prev_bs = 4'd0; prev_sc = 1'b0; prev_size = 17'd0;
        repeat (3) @(negedge clk);
        check("rst.force_bs", force_bs, 4'd0);
        check("rst.sc", sc, 1'b0);
        check("rst.rom_size", rom_size, 17'd0);
        check("rst.done", done, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 10495-byte image, no extension hint: P2
        build(10495, -1);
        play(1'b0); finish_load("p2_10495", 1'b0);
        check("p2_10495.lit", force_bs, 4'd7);

        // Reset in the middle of a load discards everything
        build(8192, 'hEA);
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            bus.ioctl_wr = 1'b1; bus.ioctl_addr = q[i].addr; bus.ioctl_dout = q[i].data;
            @(negedge clk);
        end
        reset_n = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
        #1;
        check("midrst.force_bs", force_bs, 4'd0);
        check("midrst.sc", sc, 1'b0);
        check("midrst.rom_size", rom_size, 17'd0);
        check("midrst.done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("midrst.no_done", seen_done, 1'b0);
        prev_bs = 4'd0; prev_sc = 1'b0; prev_size = 17'd0;

        // Plain 8 KiB of 0xEA after the reset: F8
        play(1'b0); finish_load("ea_8k", 1'b0);
        check("ea_8k.lit", force_bs, 4'd1);
        check("ea_8k.size_lit", rom_size, 17'd8192);

        // E0 signature at 0x100, then the same bytes split by an address gap
        build(8192, -1);
        poke('h100, 8'h8D); poke('h101, 8'hE3); poke('h102, 8'h1F);
        play(1'b0); finish_load("e0_sig", 1'b0);
        check("e0_sig.lit", force_bs, 4'd4);
        gap_from('h102);
        play(1'b0); finish_load("e0_gap", 1'b0);
        check("e0_gap.lit", force_bs, 4'd1);

        // Two 85 3F hits reach the threshold; chained straight into a load with
        // a single hit, a blank head and SuperChip forced off
        build(8192, -1);
        poke('h200, 8'h85); poke('h201, 8'h3F);
        poke('h1000, 8'h85); poke('h1001, 8'h3F);
        play(1'b0); finish_load("e3f_two", 1'b1);
        check("e3f_two.lit", force_bs, 4'd5);
        build(8192, -1);
        for (int i = 0; i < 128; i++) poke(i, 8'hFF);
        poke('h200, 8'h85); poke('h201, 8'h3F);
        set_mode(4'd0, 1'b0, 2'd1);
        play(1'b1); finish_load("e3f_one", 1'b0);
        check("e3f_one.lit", force_bs, 4'd1);
        check("e3f_one.sc_off", sc, 1'b0);

        // 16 KiB with a blank 128-byte head, auto SuperChip
        build(16384, -1);
        for (int i = 0; i < 128; i++) poke(i, 8'hFF);
        set_mode(4'd0, 1'b0, 2'd0);
        play(1'b0); finish_load("blank_16k", 1'b0);
        check("blank_16k.lit", force_bs, 4'd2);
`ifdef CART_DETECT_SC_EN
        check("blank_16k.sc_lit", sc, 1'b1);
`else
        check("blank_16k.sc_lit", sc, 1'b0);
`endif

        // Extension hint wins over the size rule
        build(4096, -1);
        set_mode(4'd9, 1'b0, 2'd2);
        play(1'b0); finish_load("ext_4k", 1'b0);
        check("ext_4k.lit", force_bs, 4'd9);
        check("ext_4k.sc_lit", sc, 1'b1);

        // Randomized short images, alternating back-to-back downloads
        chain = 1'b0;
        for (int r = 0; r < 6; r++) begin
            int n;
            bit nxt;
            wr_t w;
            n = (r == 0) ? 4096 : $urandom_range(3, 400);
            q.delete();
            for (int i = 0; i < n; i++) begin
                w.addr = 17'(i); w.data = 8'($urandom_range(0, 255));
                q.push_back(w);
            end
            repeat (2) begin
                int k, p;
                k = $urandom_range(0, 4);
                p = $urandom_range(0, n - 3);
                for (int j = 0; j < 3; j++) poke(p + j, sig[k][j]);
            end
            if ($urandom_range(0, 1) == 1) gap_from($urandom_range(1, n - 1));
            set_mode(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            nxt = (r % 2 == 0);
            play(chain);
            finish_load($sformatf("rnd%0d", r), nxt);
            chain = nxt;
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
